// File: rtl/vfd_pkg.sv
// Shared types and default constants for the VFD scan capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vfd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        HOLD   = 2'd2
    } commit_state_t;

    localparam int GRID_W_DEF     = 8;
    localparam int SEG_W_DEF      = 16;
    localparam int STABLE_CYC_DEF = 4;
    localparam int DECAY_MAX_DEF  = 15;
    localparam int TICK_DIV_DEF   = 1024;

endpackage

// File: rtl/vfd_tick_div.sv
// Free-running prescaler producing a one-cycle decay tick every TICK_DIV clocks.
// Latency: tick is combinational from the counter, high while the count sits at TICK_DIV-1.
// Backpressure: none; counts every cycle.
module vfd_tick_div
    import vfd_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..TICK_DIV-1 and wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/vfd_capture.sv
// Captures a multiplexed VFD grid/segment scan into a per-digit frame buffer with persistence decay.
// Latency: commit lands STABLE_CYC+1 clocks after the last port change; read data one clock after rd_idx.
// Backpressure: none; ports are sampled every clock and reads are always served.
module vfd_capture
    import vfd_pkg::*;
#(
    parameter int GRID_W     = GRID_W_DEF,
    parameter int SEG_W      = SEG_W_DEF,
    parameter int STABLE_CYC = STABLE_CYC_DEF,
    parameter int DECAY_MAX  = DECAY_MAX_DEF,
    parameter int TICK_DIV   = TICK_DIV_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GRID_W-1:0]         grid,
    input  logic [SEG_W-1:0]          seg,
    input  logic [$clog2(GRID_W)-1:0] rd_idx,
    output logic [SEG_W-1:0]          rd_seg,
    output logic                      rd_lit,
    output logic                      frame_strobe
);

    localparam int IDX_W = $clog2(GRID_W);
    localparam int PAT_W = GRID_W + SEG_W;
    localparam logic [3:0] STAB      = 4'(STABLE_CYC);
    localparam logic [3:0] STAB_LAST = 4'(STABLE_CYC - 1);
    localparam logic [3:0] DMAX      = 4'(DECAY_MAX);

    logic [PAT_W-1:0]  pat;
    logic [3:0]        stab_cnt;
    logic              change;
    logic              commit;
    logic              tick;
    commit_state_t     state;
    commit_state_t     state_nxt;

    logic [GRID_W-1:0] pat_grid;
    logic [SEG_W-1:0]  pat_seg;
    logic [IDX_W-1:0]  low_idx;
    logic              low_vld;
    logic [IDX_W-1:0]  last_idx;

    // Flop array: a single commit may write several digits at once.
    logic [SEG_W-1:0]  frame [GRID_W];
    logic [3:0]        decay [GRID_W];

    assign change   = ({grid, seg} != pat);
    assign commit   = (state == COMMIT);
    assign pat_grid = pat[PAT_W-1:SEG_W];
    assign pat_seg  = pat[SEG_W-1:0];

    vfd_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Sample the ports and count how long the sampled pattern has stayed unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat      <= '0;
            stab_cnt <= '0;
        end else begin
            pat <= {grid, seg};
            if (change) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STAB) begin
                stab_cnt <= stab_cnt + 4'd1;
            end
        end
    end

    // Commit state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: commit once when the count reaches its threshold; any change restarts.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (stab_cnt == STAB_LAST) state_nxt = COMMIT;
            COMMIT:  state_nxt = HOLD;
            HOLD:    state_nxt = HOLD;
            default: state_nxt = IDLE;
        endcase
        if (change) begin
            state_nxt = IDLE;
        end
    end

    // Lowest set grid bit of the pattern being committed.
    always_comb begin
        low_idx = '0;
        low_vld = 1'b0;
        for (int n = GRID_W - 1; n >= 0; n--) begin
            if (pat_grid[n]) begin
                low_idx = IDX_W'(n);
                low_vld = 1'b1;
            end
        end
    end

    // Frame writes and persistence decay; a commit reload overrides a same-cycle tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < GRID_W; n++) begin
                frame[n] <= '0;
                decay[n] <= '0;
            end
        end else begin
            for (int n = 0; n < GRID_W; n++) begin
                if (commit && pat_grid[n]) begin
                    frame[n] <= pat_seg;
                    decay[n] <= DMAX;
                end else if (tick && (decay[n] != 4'd0)) begin
                    decay[n] <= decay[n] - 4'd1;
                end
            end
        end
    end

    // Scan wrap detection: a commit landing below the previous digit starts a new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_idx     <= '0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= commit && low_vld && (low_idx < last_idx);
            if (commit && low_vld) begin
                last_idx <= low_idx;
            end
        end
    end

    // Registered read port; expired or out-of-range digits read as dark.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_seg <= '0;
            rd_lit <= 1'b0;
        end else if ((int'(rd_idx) < GRID_W) && (decay[rd_idx] != 4'd0)) begin
            rd_seg <= frame[rd_idx];
            rd_lit <= 1'b1;
        end else begin
            rd_seg <= '0;
            rd_lit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vfd_capture.sv
// Randomized and directed bench for vfd_capture with a queue-based scoreboard.
// Latency: expected read/strobe values are queued at each clock and compared on the next falling edge.
// Backpressure: n/a.
module tb_vfd_capture;

    localparam int GRID_W     = 8;
    localparam int SEG_W      = 16;
    localparam int STABLE_CYC = 4;
    localparam int DECAY_MAX  = 15;
    localparam int TICK_DIV   = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic [GRID_W-1:0] grid;
    logic [SEG_W-1:0]  seg;
    logic [2:0]        rd_idx;
    logic [SEG_W-1:0]  rd_seg;
    logic              rd_lit;
    logic              frame_strobe;

    vfd_capture #(
        .GRID_W     (GRID_W),
        .SEG_W      (SEG_W),
        .STABLE_CYC (STABLE_CYC),
        .DECAY_MAX  (DECAY_MAX),
        .TICK_DIV   (TICK_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .grid         (grid),
        .seg          (seg),
        .rd_idx       (rd_idx),
        .rd_seg       (rd_seg),
        .rd_lit       (rd_lit),
        .frame_strobe (frame_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SEG_W-1:0] seg;
        logic             lit;
        logic             strobe;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int strobe_cnt = 0;

    // Reference model state
    logic [SEG_W-1:0]        m_frame [GRID_W];
    int                      m_decay [GRID_W];
    int                      m_pre;
    int                      m_last;
    logic [GRID_W+SEG_W-1:0] m_prev;
    int                      m_run;
    bit                      m_pend;
    logic [GRID_W+SEG_W-1:0] m_pend_pat;

    function automatic int lowest(input logic [GRID_W-1:0] g);
        for (int n = 0; n < GRID_W; n++)
            if (g[n]) return n;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per rising edge, pushes the outputs the DUT should show after it.
    initial begin
        exp_t e;
        logic [GRID_W-1:0] pg;
        logic [GRID_W+SEG_W-1:0] cur;
        m_pre = 0; m_last = 0; m_prev = '0; m_run = 1; m_pend = 0; m_pend_pat = '0;
        for (int n = 0; n < GRID_W; n++) begin m_frame[n] = '0; m_decay[n] = 0; end
        forever begin
            @(posedge clk);
            if (reset) begin
                e.seg = '0; e.lit = 1'b0; e.strobe = 1'b0;
                q.push_back(e);
                for (int n = 0; n < GRID_W; n++) begin m_frame[n] = '0; m_decay[n] = 0; end
                m_pre = 0; m_last = 0; m_prev = '0; m_run = 1; m_pend = 0;
            end else begin
                e.lit    = (m_decay[rd_idx] != 0);
                e.seg    = e.lit ? m_frame[rd_idx] : '0;
                pg       = m_pend_pat[GRID_W+SEG_W-1:SEG_W];
                e.strobe = m_pend && (pg != 0) && (lowest(pg) < m_last);
                q.push_back(e);
                if (m_pre == TICK_DIV - 1)
                    for (int n = 0; n < GRID_W; n++)
                        if (m_decay[n] > 0) m_decay[n]--;
                if (m_pend) begin
                    for (int n = 0; n < GRID_W; n++)
                        if (pg[n]) begin
                            m_frame[n] = m_pend_pat[SEG_W-1:0];
                            m_decay[n] = DECAY_MAX;
                        end
                    if (pg != 0) m_last = lowest(pg);
                end
                m_pend = 0;
                m_pre  = (m_pre + 1) % TICK_DIV;
                cur    = {grid, seg};
                m_run  = (cur == m_prev) ? m_run + 1 : 1;
                m_prev = cur;
                if (m_run == STABLE_CYC + 1) begin
                    m_pend     = 1;
                    m_pend_pat = cur;
                end
            end
        end
    end

    // Monitor: pop the expected outputs and compare against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                check("rd_seg", 32'(rd_seg), 32'(e.seg));
                check("rd_lit", 32'(rd_lit), 32'(e.lit));
                check("frame_strobe", 32'(frame_strobe), 32'(e.strobe));
                if (frame_strobe === 1'b1) strobe_cnt++;
            end
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1; grid = '0; seg = '0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic hold(input logic [GRID_W-1:0] g, input logic [SEG_W-1:0] s,
                        input int cyc, input int idx);
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            grid   = g;
            seg    = s;
            rd_idx = (idx < 0) ? 3'($urandom_range(0, GRID_W - 1)) : 3'(idx);
        end
    endtask

    // Stimulus
    initial begin
        int guard;
        logic [GRID_W-1:0] g;
        reset = 1'b1; grid = '0; seg = '0; rd_idx = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Single digit commit, read back digit 2
        hold(8'h04, 16'h00FF, 8, 2);
        hold(8'h00, 16'h0000, 4, 2);

        // Pattern toggling faster than the stability window never commits
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            hold(8'h01, 16'h1111, 3, -1);
            hold(8'h02, 16'h2222, 3, -1);
        end
        for (int i = 0; i < GRID_W; i++) hold(8'h02, 16'h2222, 1, i);

        // Reset in mid-count aborts the pending commit
        do_reset(2);
        hold(8'h04, 16'hABCD, 3, 2);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        hold(8'h04, 16'hABCD, 3, 2);
        hold(8'h04, 16'hABCD, 8, 2);

        // Scan 0..7 then wrap to 0: exactly one strobe
        do_reset(2);
        strobe_cnt = 0;
        for (int d = 0; d < GRID_W; d++) begin
            hold(8'(1 << d), 16'(d * 16'h1111), 6, -1);
            hold(8'h00, 16'h0000, 2, -1);
        end
        hold(8'h01, 16'hF0F0, 6, -1);
        hold(8'h00, 16'h0000, 3, -1);
        @(negedge clk);
        check("scan_strobe_count", 32'(strobe_cnt), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       g = '0;
                1:       g = 8'($urandom);
                default: g = 8'(1 << $urandom_range(0, GRID_W - 1));
            endcase
            hold(g, 16'($urandom), ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3)
                                                               : $urandom_range(6, 9), -1);
        end

        // Two-digit commit, digit 1 commit, then recommit aligned with a decay tick
        do_reset(2);
        hold(8'h81, 16'h1234, 8, -1);
        hold(8'h02, 16'h5A5A, 8, -1);
        guard = 0;
        while (m_pre != TICK_DIV - 7 && guard < 2 * TICK_DIV) begin
            hold(8'h00, 16'h0000, 1, -1);
            guard++;
        end
        check("tick_align_bound", 32'(guard < 2 * TICK_DIV), 32'd1);
        hold(8'h81, 16'h1234, 8, 0);

        // Idle long enough for every digit to decay out
        for (int i = 0; i < (DECAY_MAX + 1) * TICK_DIV + 200; i++)
            hold(8'h00, 16'h0000, 1, -1);
        for (int i = 0; i < GRID_W; i++) hold(8'h00, 16'h0000, 1, i);

        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vfd_capture.md
VFD_CAPTURE -- requirements
Module: vfd_capture

Interface
REQ-001 Parameter GRID_W, default 8, number of grid lines (display digits).
REQ-002 Parameter SEG_W, default 16, number of segment lines per grid.
REQ-003 Parameter STABLE_CYC, default 4, clk cycles a port pattern must hold before commit (range 1..15).
REQ-004 Parameter DECAY_MAX, default 15, persistence reload value, 4-bit.
REQ-005 Parameter TICK_DIV, default 1024, clk cycles per decay tick, at least 2.
REQ-006 clk  in  1  system clock, same clock as the MCU core; clock enables are internal only.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 grid  in  GRID_W  MCU grid-port outputs; bit n high selects digit n.
REQ-009 seg  in  SEG_W  MCU segment-port outputs; bit high lights the segment.
REQ-010 rd_idx  in  clog2(GRID_W)  frame-buffer read index.
REQ-011 rd_seg  out  SEG_W  segments of digit rd_idx, registered.
REQ-012 rd_lit  out  1  persistence counter of rd_idx is non-zero, registered.
REQ-013 frame_strobe  out  1  one-cycle pulse when the scan wraps.

Function
REQ-014 Sample {grid,seg} every clk into a pattern register and compare it against the previous sample.
REQ-015 Any change in the pattern SHALL reset the stability counter to 0; otherwise the counter increments and saturates at STABLE_CYC.
REQ-016 A commit occurs in the single cycle the counter reaches STABLE_CYC, which is at least STABLE_CYC cycles after the last change; a held pattern commits once only.
REQ-017 On commit with grid == 0, no write occurs; this is blanking between strobes.
REQ-018 On commit, for every set grid bit n: frame[n] <= seg and decay[n] <= DECAY_MAX; multiple active bits write all.
REQ-019 Tick prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick at wrap.
REQ-020 On tick, every decay[n] > 0 decrements by 1; at 0 it holds, and frame[n] holds its data.
REQ-021 If a commit and a tick hit the same digit in the same cycle, the commit reload wins.
REQ-022 rd_seg SHALL be frame[rd_idx] when decay[rd_idx] != 0, else 0; rd_seg and rd_lit update one clk after rd_idx is applied.
REQ-023 If rd_idx >= GRID_W, rd_seg = 0 and rd_lit = 0.
REQ-024 Scan tracking: last_idx holds the lowest set bit of the last committed non-zero grid; frame_strobe pulses the cycle after a commit whose lowest index < last_idx.
REQ-025 Commit states: IDLE (counting), COMMIT (one cycle, writes), HOLD (pattern stable, waiting for change); a change returns the block to IDLE from any state.

Reset
REQ-026 Reset clears frame[], decay[], pattern, the stability counter, the prescaler and last_idx; it sets last_idx = 0 and forces the state to IDLE.
REQ-027 While reset is high, rd_seg = 0, rd_lit = 0 and frame_strobe = 0.
REQ-028 Reset asserted during the stability count aborts the pending commit with no write.

Structure
REQ-029 A shared package vfd_pkg holds the state enum (IDLE, COMMIT, HOLD) and the default parameter constants.
REQ-030 The prescaler is one sub-module, vfd_tick_div, with parameter TICK_DIV and output tick.
REQ-031 frame[] is a GRID_W x SEG_W register array, inferred as flops rather than BRAM, because of the parallel multi-write.

Verification
REQ-032 grid=8'h04, seg=16'h00FF held 4 cycles -> commit at cycle 4; rd_idx=2 -> rd_seg=16'h00FF, rd_lit=1 the next cycle.
REQ-033 Pattern toggles every 3 cycles with STABLE_CYC=4 -> no commit; all rd_lit=0.
REQ-034 Commit on digit 1, then no further commits -> rd_lit falls after 15 ticks (15*1024 cycles, +-1 tick); rd_seg=0 thereafter.
REQ-035 Scan digits 0..7 in order, then digit 0 -> exactly one frame_strobe pulse, the cycle after the digit-0 commit.
REQ-036 grid=8'h81, seg=16'h1234 committed -> frame[0]=frame[7]=16'h1234; commit coincident with tick on digit 0 -> decay[0]=15.
REQ-037 Assert reset at stability count 2 -> after release, rd_lit=0 for all digits; a fresh 4-cycle hold is needed to commit.
